// File: rtl/ro_puf_sequencer_if.sv
// Signal bundle between the RO PUF sequencer, its host and the RO mux/counter datapath.
// Latency: none, wires only.
// Backpressure: none; start is a level request, accepted only while the sequencer is idle.
interface ro_puf_sequencer_if #(
  parameter int N_BITS = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  challenge;
  logic [CNT_W-1:0]  count_a;
  logic [CNT_W-1:0]  count_b;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              ro_en;
  logic              cnt_clr;
  logic              cnt_en;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] response;
  logic [N_BITS-1:0] unstable;

  // Sequencer side
  modport master (
    input  start, abort, challenge, count_a, count_b,
    output sel_a, sel_b, ro_en, cnt_clr, cnt_en, busy, done, response, unstable
  );

  // Host / datapath side
  modport slave (
    output start, abort, challenge, count_a, count_b,
    input  sel_a, sel_b, ro_en, cnt_clr, cnt_en, busy, done, response, unstable
  );
endinterface

// File: rtl/ro_puf_sequencer.sv
// Walks N_BITS RO pairs (settle, count window, compare) and builds response/unstable masks.
// Latency: done is high in the DONE state, N_BITS*(SETTLE_CYC+WINDOW_CYC+1)+1 cycles counted from the start edge.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next edge.
module ro_puf_sequencer #(
  parameter int N_BITS     = 8,
  parameter int SEL_W      = 4,
  parameter int CNT_W      = 32,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1024,
  parameter int MARGIN     = 4
) (
  input  logic               clk,
  input  logic               rst,
  ro_puf_sequencer_if.master bus
);

  localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] tmr;
  logic             accept;
  logic             last_bit;
  logic             settle_end;
  logic             measure_end;
  logic             a_gt_b;
  logic [CNT_W:0]   diff;

  assign last_bit    = (idx == IDX_W'(N_BITS - 1));
  assign settle_end  = (tmr == TMR_W'(SETTLE_CYC - 1));
  assign measure_end = (tmr == TMR_W'(WINDOW_CYC - 1));

  // Magnitude of the count difference, one bit wider so a full-scale gap cannot wrap.
  assign a_gt_b = (bus.count_a > bus.count_b);
  assign diff   = a_gt_b ? ({1'b0, bus.count_a} - {1'b0, bus.count_b})
                         : ({1'b0, bus.count_b} - {1'b0, bus.count_a});

  // State register; reset drops straight to IDLE, which forces all control outputs low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore control outputs; abort overrides every non-idle transition.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    bus.ro_en   = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.cnt_en  = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        bus.ro_en   = 1'b1;
        bus.cnt_clr = 1'b1;
        bus.busy    = 1'b1;
        if (settle_end) state_nxt = MEASURE;
      end
      MEASURE: begin
        bus.ro_en  = 1'b1;
        bus.cnt_en = 1'b1;
        bus.busy   = 1'b1;
        if (measure_end) state_nxt = COMPARE;
      end
      COMPARE: begin
        bus.ro_en = 1'b1;
        bus.busy  = 1'b1;
        state_nxt = last_bit ? DONE : SETTLE;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) state_nxt = IDLE;
  end

  // Phase timer: counts cycles spent in SETTLE/MEASURE, restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if ((state_nxt != state) || !(state == SETTLE || state == MEASURE)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  // Bit index, pair selects and result capture; an aborted compare leaves results untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      bus.sel_a    <= '0;
      bus.sel_b    <= '0;
      bus.response <= '0;
      bus.unstable <= '0;
    end else if (accept) begin
      idx          <= '0;
      bus.sel_a    <= bus.challenge;
      bus.sel_b    <= bus.challenge + SEL_W'(1);
      bus.response <= '0;
      bus.unstable <= '0;
    end else if (state == COMPARE && !bus.abort) begin
      bus.response[idx] <= a_gt_b;
      bus.unstable[idx] <= (diff < (CNT_W + 1)'(MARGIN));
      if (!last_bit) begin
        idx       <= idx + IDX_W'(1);
        bus.sel_a <= bus.sel_a + SEL_W'(1);
        bus.sel_b <= bus.sel_b + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Bench for ro_puf_sequencer: cycle-accurate control checks plus a result scoreboard.
// Latency: expects done in cycle 45 after the start edge for the 4-bit, 2+8+1 configuration.
// Backpressure: exercises start-while-busy, abort, async reset and start+abort in IDLE.
module tb_ro_puf_sequencer;
  localparam int N_BITS = 4;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 32;
  localparam int PER    = 11;  // SETTLE 2 + WINDOW 8 + COMPARE 1

  typedef struct packed {
    logic [N_BITS-1:0] resp;
    logic [N_BITS-1:0] unst;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  res_t exp_q[$];
  logic [CNT_W-1:0] ca[N_BITS];
  logic [CNT_W-1:0] cb[N_BITS];
  logic [4:0] ctrl;

  always #5 clk = ~clk;

  ro_puf_sequencer_if #(.N_BITS(N_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  ro_puf_sequencer #(
    .N_BITS(N_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W),
    .SETTLE_CYC(2), .WINDOW_CYC(8), .MARGIN(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign ctrl = {bus.ro_en, bus.cnt_clr, bus.cnt_en, bus.busy, bus.done};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {ro_en, cnt_clr, cnt_en, busy, done} in cycle cyc (cycle 1 = first after start edge).
  function automatic logic [4:0] exp_ctrl(input int cyc);
    int ph;
    ph = (cyc - 1) % PER;
    if (cyc >= 1 && cyc <= N_BITS * PER) begin
      if (ph < 2)       exp_ctrl = 5'b11010;
      else if (ph < 10) exp_ctrl = 5'b10110;
      else              exp_ctrl = 5'b10010;
    end else if (cyc == N_BITS * PER + 1) begin
      exp_ctrl = 5'b00011;
    end else begin
      exp_ctrl = 5'b00000;
    end
  endfunction

  task automatic sample_done();
    res_t e;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("response", 64'(bus.response), 64'(e.resp));
        check("unstable", 64'(bus.unstable), 64'(e.unst));
      end
    end
  endtask

  // One measurement run; abort_cyc > 0 raises abort during that cycle, spam holds start while busy.
  task automatic run(input logic [SEL_W-1:0] chal, input logic [N_BITS-1:0] er,
                     input logic [N_BITS-1:0] eu, input int abort_cyc, input bit spam);
    logic [SEL_W-1:0] sa;
    int b;
    int ph;
    @(negedge clk);
    bus.challenge = chal;
    bus.start     = 1'b1;
    if (abort_cyc <= 0) exp_q.push_back('{resp: er, unst: eu});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= N_BITS * PER + 2; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      b  = (cyc - 1) / PER;
      ph = (cyc - 1) % PER;
      if (b < N_BITS) begin
        bus.count_a = ca[b];
        bus.count_b = cb[b];
      end
      bus.start = spam && cyc >= 3 && cyc <= 30;
      if (spam) bus.challenge = 3'd0;
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        check("abort_ctrl", 64'(ctrl), 64'd0);
        bus.abort = 1'b0;
        break;
      end
      check("ctrl", 64'(ctrl), 64'(exp_ctrl(cyc)));
      if (b < N_BITS && (ph == 0 || ph == 10)) begin
        sa = chal + SEL_W'(b);
        check("sel", 64'({bus.sel_a, bus.sel_b}), 64'({sa, SEL_W'(sa + 3'd1)}));
      end
      sample_done();
      if (cyc == abort_cyc) bus.abort = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic set_counts(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    for (int i = 0; i < N_BITS; i++) begin
      ca[i] = a;
      cb[i] = b;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.challenge = '0;
    bus.count_a   = '0;
    bus.count_b   = '0;
    set_counts(32'd100, 32'd90);
    #12;
    check("rst_ctrl", 64'(ctrl), 64'd0);
    check("rst_sel", 64'({bus.sel_a, bus.sel_b}), 64'd0);
    check("rst_result", 64'({bus.response, bus.unstable}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal: A beats B everywhere by a wide margin.
    run(3'd3, 4'b1111, 4'b0000, 0, 1'b0);

    // Tie, near-tie, B wins, full-scale gap.
    ca[0] = 32'd50; cb[0] = 32'd50;
    ca[1] = 32'd52; cb[1] = 32'd49;
    ca[2] = 32'd40; cb[2] = 32'd60;
    ca[3] = 32'd0;  cb[3] = 32'hFFFF_FFFF;
    run(3'd5, 4'b0010, 4'b0011, 0, 1'b0);

    // Select wrap-around, with start held high while busy.
    set_counts(32'd100, 32'd90);
    run(3'd6, 4'b1111, 4'b0000, 0, 1'b1);

    // Abort in MEASURE of bit 2: partial result kept, no done.
    ca[2] = 32'd10; cb[2] = 32'd90;
    run(3'd2, 4'b0000, 4'b0000, 28, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      sample_done();
      check("abort_idle", 64'(ctrl), 64'd0);
    end
    check("abort_partial", 64'({bus.response, bus.unstable}), 64'({4'b0011, 4'b0000}));

    // A following start runs normally.
    set_counts(32'd7, 32'd300);
    run(3'd1, 4'b0000, 4'b0000, 0, 1'b0);
    set_counts(32'd100, 32'd90);
    run(3'd0, 4'b1111, 4'b0000, 0, 1'b0);

    // Async reset between edges mid-SETTLE.
    @(negedge clk);
    bus.challenge = 3'd4;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("pre_rst_busy", 64'(ctrl), 64'(5'b11010));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ctrl", 64'(ctrl), 64'd0);
    check("async_rst_sel", 64'({bus.sel_a, bus.sel_b}), 64'd0);
    check("async_rst_result", 64'({bus.response, bus.unstable}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", 64'(ctrl), 64'd0);

    // start together with abort in IDLE is rejected.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    check("start_abort_rej", 64'(ctrl), 64'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    check("start_abort_idle", 64'(ctrl), 64'd0);

    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
